// File: rtl/serial_adder_ctrl.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flip-flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] ra_reg;
    logic [WIDTH-1:0] rb_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             bit_s;
    logic             carry_next;
    logic             load;

    // Full-adder cell fed by the operand LSBs and the carry flip-flop
    assign bit_s      = ra_reg[0] ^ rb_reg[0] ^ c_reg;
    assign carry_next = (ra_reg[0] & rb_reg[0]) | (ra_reg[0] & c_reg) | (rb_reg[0] & c_reg);

    // Result shifts right; each new sum bit enters at the MSB
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_res
            if (gi == WIDTH - 1) begin : g_top
                assign res_next[gi] = bit_s;
            end else begin : g_mid
                assign res_next[gi] = res_reg[gi+1];
            end
        end
    endgenerate

    assign load = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            res_reg   <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (load) begin
            ra_reg    <= a;
            rb_reg    <= b;
            c_reg     <= cin;
            cnt_reg   <= '0;
            state_reg <= S_RUN;
        end else begin
            case (state_reg)
                S_RUN: begin
                    c_reg   <= carry_next;
                    ra_reg  <= ra_reg >> 1;
                    rb_reg  <= rb_reg >> 1;
                    res_reg <= res_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        sum_reg   <= res_next;
                        cout_reg  <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // c_reg here is the carry into the MSB cell
                        ovf_reg   <= c_reg ^ carry_next;
`endif
                        state_reg <= S_DONE;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == S_RUN);
    assign done = (state_reg == S_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule
